// File: rtl/fifo_pkg.sv
// Shared types for the FIFO burst reader: FSM states,
// count-width helper and skid buffer entry format.
package fifo_pkg;

   localparam int DW = 8;

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      DRAIN
   } rd_state_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } skid_entry_t;

   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer between FIFO read data and the
// downstream valid/ready sink; head is entry 0.
module fifo_rd_skid
   import fifo_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  skid_entry_t push_entry,
   input  logic        pop,
   output logic [1:0]  count,
   output logic        valid,
   output skid_entry_t head
);

   skid_entry_t e0, e1;
   logic push_ok, pop_ok;

   always_comb begin
      pop_ok  = pop && (count != 2'd0);
      push_ok = push && ((count != 2'd2) || pop_ok);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 2'd0;
         e0    <= '0;
         e1    <= '0;
      end else begin
         unique case ({push_ok, pop_ok})
            2'b10: begin
               if (count == 2'd0) e0 <= push_entry;
               else               e1 <= push_entry;
               count <= count + 2'd1;
            end
            2'b01: begin
               e0    <= e1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  e0 <= push_entry;
               end else begin
                  e0 <= e1;
                  e1 <= push_entry;
               end
            end
            default: ;
         endcase
      end
   end

   assign valid = (count != 2'd0);
   assign head  = e0;

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller: drains the FIFO in bounded bursts on
// threshold or timeout and streams beats to a valid/ready sink.
module fifo_burst_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DW,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_WIDTH  = cnt_width(FIFO_DEPTH),
   parameter int BURST_MAX  = 8,
   parameter int TIMEOUT    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic                  fifo_thr_trig,
   input  logic [CNT_WIDTH-1:0]  fifo_count,
   output logic                  fifo_rd,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  timeout_flush
);

   localparam int TW = $clog2(TIMEOUT) + 1;

   rd_state_t            state, state_nx;
   logic [CNT_WIDTH-1:0] rem, rem_nx, burst_len;
   logic [TW-1:0]        tcnt, tcnt_nx;
   logic                 tflush_nx;
   logic                 inflight, inflight_last;
   logic                 rd, pop;
   logic [1:0]           sk_count;
   logic [2:0]           occ;
   skid_entry_t          head;

   assign burst_len = (fifo_count > CNT_WIDTH'(BURST_MAX)) ?
                      CNT_WIDTH'(BURST_MAX) : fifo_count;
   assign pop = m_valid && m_ready;
   // Credit the beat leaving this cycle so reads sustain 1/cycle
   assign occ = {1'b0, sk_count} + {2'b0, inflight} - {2'b0, pop};

   always_comb begin
      state_nx  = state;
      rem_nx    = rem;
      tcnt_nx   = '0;
      tflush_nx = 1'b0;
      rd        = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable && fifo_thr_trig) begin
               if (burst_len != '0) begin
                  rem_nx   = burst_len;
                  state_nx = BURST;
               end
            end else if (enable && !fifo_empty) begin
               if (tcnt == TW'(TIMEOUT - 2)) begin
                  if (burst_len != '0) begin
                     rem_nx    = burst_len;
                     state_nx  = BURST;
                     tflush_nx = 1'b1;
                  end
               end else begin
                  tcnt_nx = tcnt + TW'(1);
               end
            end
         end
         BURST: begin
            rd = (rem != '0) && !fifo_empty && (occ < 3'd2);
            if (rd) begin
               rem_nx = rem - CNT_WIDTH'(1);
               if (rem == CNT_WIDTH'(1)) state_nx = DRAIN;
            end
         end
         DRAIN: begin
            if (sk_count == 2'd0 && !inflight) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign fifo_rd = rd && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         rem           <= '0;
         tcnt          <= '0;
         timeout_flush <= 1'b0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         state         <= state_nx;
         rem           <= rem_nx;
         tcnt          <= tcnt_nx;
         timeout_flush <= tflush_nx;
         inflight      <= fifo_rd;
         inflight_last <= fifo_rd && (rem == CNT_WIDTH'(1));
      end
   end

   fifo_rd_skid u_skid (
      .clk        (clk),
      .rst        (rst),
      .push       (inflight),
      .push_entry ('{data: fifo_dout, last: inflight_last}),
      .pop        (pop),
      .count      (sk_count),
      .valid      (m_valid),
      .head       (head)
   );

   assign m_data = head.data;
   assign m_last = head.last && m_valid;
   assign busy   = (state != IDLE) || (sk_count != 2'd0);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural
// FIFO model and a beat monitor.
module tb_fifo_burst_reader;
   import fifo_pkg::*;

   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst, enable, fifo_thr_trig, m_ready;
   logic          fifo_empty, fifo_rd, m_valid, m_last;
   logic          busy, timeout_flush;
   logic [CW-1:0] fifo_count;
   logic [7:0]    fifo_dout = 8'h00;
   logic [7:0]    m_data;

   always #5 clk = ~clk;

   fifo_burst_reader dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .fifo_empty    (fifo_empty),
      .fifo_thr_trig (fifo_thr_trig),
      .fifo_count    (fifo_count),
      .fifo_rd       (fifo_rd),
      .fifo_dout     (fifo_dout),
      .m_valid       (m_valid),
      .m_data        (m_data),
      .m_last        (m_last),
      .m_ready       (m_ready),
      .busy          (busy),
      .timeout_flush (timeout_flush)
   );

   logic [7:0] mem [256];
   int wp = 0;
   int rp = 0;

   assign fifo_count = CW'(wp - rp);
   assign fifo_empty = (wp == rp);

   always @(posedge clk) begin
      if (fifo_rd) begin
         fifo_dout <= mem[rp];
         rp        <= rp + 1;
      end
   end

   int         rd_cnt = 0, uf_cnt = 0, tf_cnt = 0, nbeat = 0;
   int         stab_err = 0, occ_err = 0;
   logic [7:0] gd [256];
   logic       gl [256];
   logic       stalled = 1'b0;
   logic [7:0] held = 8'h00;

   always @(posedge clk) begin
      if (fifo_rd) rd_cnt <= rd_cnt + 1;
      if (fifo_rd && fifo_empty) uf_cnt <= uf_cnt + 1;
      if (timeout_flush) tf_cnt <= tf_cnt + 1;
      if (m_valid && m_ready) begin
         gd[nbeat] <= m_data;
         gl[nbeat] <= m_last;
         nbeat     <= nbeat + 1;
      end
      if (stalled && (!m_valid || m_data !== held))
         stab_err <= stab_err + 1;
      stalled <= m_valid && !m_ready && !rst;
      held    <= m_data;
      if (dut.u_skid.count > 2'd2) occ_err <= occ_err + 1;
   end

   int vec = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         mem[wp] = 8'(base + i);
         wp++;
      end
   endtask

   task automatic wait_beats(input int target, input int lim,
                             input string tag);
      int t = 0;
      while (nbeat < target && t < lim) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_beats_bound"}, 32'(nbeat >= target), 32'd1);
   endtask

   task automatic wait_idle(input int lim, input string tag);
      int t = 0;
      while (busy && t < lim) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_idle_bound"}, 32'(busy), 32'd0);
   endtask

   task automatic chk_seq(input int b0, input int n, input int d0,
                          input string tag);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_data%0d", tag, i), 32'(gd[b0+i]),
             32'(8'(d0 + i)));
         chk($sformatf("%s_last%0d", tag, i), 32'(gl[b0+i]),
             32'(i == n - 1));
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rd"},    32'(fifo_rd),       32'd0);
      chk({tag, "_valid"}, 32'(m_valid),       32'd0);
      chk({tag, "_last"},  32'(m_last),        32'd0);
      chk({tag, "_busy"},  32'(busy),          32'd0);
      chk({tag, "_tf"},    32'(timeout_flush), 32'd0);
      chk({tag, "_data"},  32'(m_data),        32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, rd0, tf0, k, t, nb;
      logic early;
      rst = 1'b1;
      enable = 1'b0;
      fifo_thr_trig = 1'b0;
      m_ready = 1'b1;
      step(3);
      chk_zero("reset");
      rst = 1'b0;
      step(1);

      // 5 words, trigger, sustained ready
      push(5, 'h10);
      b = nbeat;
      rd0 = rd_cnt;
      enable = 1'b1;
      fifo_thr_trig = 1'b1;
      step(1);
      chk("t1_rd_first", 32'(fifo_rd), 32'd1);
      chk("t1_valid_c1", 32'(m_valid), 32'd0);
      fifo_thr_trig = 1'b0;
      step(1);
      chk("t1_valid_c2", 32'(m_valid), 32'd0);
      step(1);
      chk("t1_valid_c3", 32'(m_valid), 32'd1);
      chk("t1_data_c3", 32'(m_data), 32'h10);
      wait_beats(b + 5, 40, "t1");
      chk("t1_busy_hs", 32'(busy), 32'd1);
      step(1);
      chk("t1_busy_fall", 32'(busy), 32'd0);
      chk("t1_rd_count", 32'(rd_cnt - rd0), 32'd5);
      chk_seq(b, 5, 'h10, "t1");

      // 12 words, trigger held: 8 then 4
      push(12, 'h20);
      b = nbeat;
      rd0 = rd_cnt;
      fifo_thr_trig = 1'b1;
      wait_beats(b + 12, 80, "t2");
      fifo_thr_trig = 1'b0;
      wait_idle(20, "t2");
      chk("t2_rd_count", 32'(rd_cnt - rd0), 32'd12);
      chk_seq(b, 8, 'h20, "t2a");
      chk_seq(b + 8, 4, 'h28, "t2b");

      // 3 words, no trigger: timeout flush
      b = nbeat;
      rd0 = rd_cnt;
      tf0 = tf_cnt;
      push(3, 'h40);
      early = 1'b0;
      repeat (30) begin
         step(1);
         if (timeout_flush || fifo_rd) early = 1'b1;
      end
      chk("t3_no_early", 32'(early), 32'd0);
      step(1);
      chk("t3_tf_pulse", 32'(timeout_flush), 32'd1);
      step(1);
      chk("t3_tf_end", 32'(timeout_flush), 32'd0);
      wait_beats(b + 3, 40, "t3");
      wait_idle(20, "t3");
      chk_seq(b, 3, 'h40, "t3");
      chk("t3_rd_count", 32'(rd_cnt - rd0), 32'd3);
      chk("t3_tf_count", 32'(tf_cnt - tf0), 32'd1);

      // 6 words, ready pattern 1,0,0,1
      push(6, 'h50);
      b = nbeat;
      rd0 = rd_cnt;
      fifo_thr_trig = 1'b1;
      k = 0;
      t = 0;
      while (nbeat < b + 6 && t < 100) begin
         m_ready = (k % 4 == 0) || (k % 4 == 3);
         k++;
         t++;
         step(1);
         fifo_thr_trig = 1'b0;
      end
      m_ready = 1'b1;
      chk("t4_beats_bound", 32'(nbeat >= b + 6), 32'd1);
      wait_idle(20, "t4");
      chk_seq(b, 6, 'h50, "t4");
      chk("t4_rd_count", 32'(rd_cnt - rd0), 32'd6);
      chk("t4_stable", 32'(stab_err), 32'd0);
      chk("t4_occ", 32'(occ_err), 32'd0);

      // reset on the 3rd beat
      push(6, 'h60);
      b = nbeat;
      fifo_thr_trig = 1'b1;
      wait_beats(b + 2, 40, "t5");
      chk("t5_beat3_valid", 32'(m_valid), 32'd1);
      chk("t5_beat3_data", 32'(m_data), 32'h62);
      rst = 1'b1;
      fifo_thr_trig = 1'b0;
      enable = 1'b0;
      step(1);
      chk_zero("t5_rst");
      chk("t5_state", 32'(dut.state), 32'(IDLE));
      rst = 1'b0;
      rd0 = rd_cnt;
      nb = nbeat;
      step(10);
      chk("t5_no_rd", 32'(rd_cnt - rd0), 32'd0);
      chk("t5_no_beat", 32'(nbeat - nb), 32'd0);
      enable = 1'b1;
      fifo_thr_trig = 1'b1;
      t = 0;
      while ((!fifo_empty || busy || t < 2) && t < 60) begin
         step(1);
         t++;
      end
      fifo_thr_trig = 1'b0;
      chk("t5_cleanup", 32'(fifo_empty && !busy), 32'd1);

      // enable gating
      enable = 1'b0;
      fifo_thr_trig = 1'b1;
      push(10, 'h70);
      rd0 = rd_cnt;
      b = nbeat;
      step(10);
      chk("t6_disabled", 32'(rd_cnt - rd0), 32'd0);
      enable = 1'b1;
      wait_beats(b + 2, 40, "t6a");
      enable = 1'b0;
      wait_beats(b + 8, 40, "t6b");
      step(20);
      chk("t6_rd_count", 32'(rd_cnt - rd0), 32'd8);
      chk("t6_beats", 32'(nbeat - b), 32'd8);
      chk_seq(b, 8, 'h70, "t6");
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_left", 32'(fifo_count), 32'd2);
      chk("underflow", 32'(uf_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
      $finish;
   end

endmodule
